// File: rtl/pixel_stream_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_stream_sequencer
//
// Walks the (x, y) word coordinates of each video frame, presents them to the
// downstream pixel datapath (which answers combinationally on pix_data) and
// registers the returned word onto an AXI-Stream master with SOF on tuser and
// EOL on tlast. Frames start on ctrl_run (continuous) or a ctrl_single pulse
// (one frame) and are never truncated once started.
//
// Optional feature macro: PIXSEQ_LINE_GAP_EN
//   When defined, LINE_GAP idle cycles (tvalid=0) are inserted after each EOL
//   handshake except the one that ends the stream. When undefined, lines and
//   frames are streamed back-to-back.
//
// Ports:
//   out_stream_aclk      sole clock
//   periph_resetn        asynchronous active-low reset
//   ctrl_run             level, stream frames continuously while high
//   ctrl_single          one-cycle pulse, stream exactly one frame
//   pix_x / pix_y        coordinate of the word being requested
//   pix_data             datapath word for (pix_x, pix_y), same cycle
//   out_stream_t*        AXI-Stream master (tkeep constant 4'hF)
//   busy                 sequencer is not idle
//   frame_count          completed frames, wraps at 16 bits
//
// States:
//   IDLE   | counters held at 0, waiting for ctrl_run / ctrl_single
//   ACTIVE | loading one word per free output slot
//   GAP    | (macro only) waiting for EOL handshake, then idle LINE_GAP cycles
//   FLUSH  | no loads, waiting for the final beat of the stream to handshake
// ---------------------------------------------------------------------------
module pixel_stream_sequencer #(
    parameter int X_SIZE   = 480,
    parameter int Y_SIZE   = 480,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int LINE_GAP = 4
) (
    input  logic          out_stream_aclk,
    input  logic          periph_resetn,
    input  logic          ctrl_run,
    input  logic          ctrl_single,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    input  logic [31:0]   pix_data,
    output logic [31:0]   out_stream_tdata,
    output logic [3:0]    out_stream_tkeep,
    output logic          out_stream_tlast,
    output logic          out_stream_tuser,
    output logic          out_stream_tvalid,
    input  logic          out_stream_tready,
    output logic          busy,
    output logic [15:0]   frame_count
);

    if (X_SIZE < 2 || Y_SIZE < 2 || (1 << XW) < X_SIZE || (1 << YW) < Y_SIZE ||
        LINE_GAP < 1) begin : g_bad_params
        $error("pixel_stream_sequencer: illegal parameter set");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd3;
`ifdef PIXSEQ_LINE_GAP_EN
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam int         GW       = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
`endif

    logic [1:0]    state_q, state_d;
    logic          single_q, single_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;
    logic [15:0]   frame_count_q, frame_count_d;
`ifdef PIXSEQ_LINE_GAP_EN
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic load;
    logic hs;
    logic x_last;
    logic y_last;
    logic keep_running;

    always_comb begin
        state_d       = state_q;
        single_d      = single_q;
        x_d           = x_q;
        y_d           = y_q;
        tdata_d       = tdata_q;
        tuser_d       = tuser_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        frame_count_d = frame_count_q;
`ifdef PIXSEQ_LINE_GAP_EN
        gap_cnt_d     = gap_cnt_q;
`endif

        load         = (state_q == S_ACTIVE) && (!tvalid_q || out_stream_tready);
        hs           = tvalid_q && out_stream_tready;
        x_last       = (x_q == XW'(X_SIZE - 1));
        y_last       = (y_q == YW'(Y_SIZE - 1));
        keep_running = ctrl_run && !single_q;

        if (load) begin
            tdata_d  = pix_data;
            tuser_d  = (x_q == '0) && (y_q == '0);
            tlast_d  = x_last;
            tvalid_d = 1'b1;
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end else if (out_stream_tready) begin
            tvalid_d = 1'b0;
        end

        // Counters sit at (0,0) only after the last word of a frame was loaded,
        // so an EOL handshake seen there is the end of a frame.
        if (hs && tlast_q && (x_q == '0) && (y_q == '0)) begin
            frame_count_d = frame_count_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (ctrl_run || ctrl_single) begin
                    state_d  = S_ACTIVE;
                    single_d = ctrl_single && !ctrl_run;
                end
            end
            S_ACTIVE: begin
                if (load && x_last && y_last && !keep_running) begin
                    state_d = S_FLUSH;
                end
`ifdef PIXSEQ_LINE_GAP_EN
                else if (load && x_last) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GW'(LINE_GAP - 1);
                end
`endif
            end
`ifdef PIXSEQ_LINE_GAP_EN
            // The EOL beat may still be stalled; the count only runs once the
            // slot is free. Terminal count hands back to ACTIVE, whose first
            // cycle is the last idle one.
            S_GAP: begin
                if (!tvalid_q || out_stream_tready) begin
                    if (gap_cnt_q == '0) begin
                        state_d = S_ACTIVE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
            end
`endif
            S_FLUSH: begin
                if (hs) begin
                    state_d  = S_IDLE;
                    single_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q       <= S_IDLE;
            single_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            tdata_q       <= '0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
            frame_count_q <= '0;
`ifdef PIXSEQ_LINE_GAP_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            single_q      <= single_d;
            x_q           <= x_d;
            y_q           <= y_d;
            tdata_q       <= tdata_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            tvalid_q      <= tvalid_d;
            frame_count_q <= frame_count_d;
`ifdef PIXSEQ_LINE_GAP_EN
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    assign pix_x             = x_q;
    assign pix_y             = y_q;
    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tvalid = tvalid_q;
    assign busy              = (state_q != S_IDLE);
    assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_stream_sequencer
//
// Directed bench for pixel_stream_sequencer with a 4x3 frame. The datapath
// stub answers {pix_y, pix_x}; every beat is compared against the word, SOF
// and EOL expected for its position in the stream, which the bench derives
// from its own beat index.
// ---------------------------------------------------------------------------
module tb_pixel_stream_sequencer;

    localparam int X_SIZE      = 4;
    localparam int Y_SIZE      = 3;
    localparam int XW          = 10;
    localparam int YW          = 10;
    localparam int LINE_GAP    = 4;
    localparam int FRAME_BEATS = X_SIZE * Y_SIZE;
`ifdef PIXSEQ_LINE_GAP_EN
    localparam int GAP_CYC = LINE_GAP;
`else
    localparam int GAP_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_run;
    logic          ctrl_single;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [31:0]   pix_data;
    logic [31:0]   tdata;
    logic [3:0]    tkeep;
    logic          tlast;
    logic          tuser;
    logic          tvalid;
    logic          tready;
    logic          busy;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    assign pix_data = {12'd0, pix_y, pix_x};

    pixel_stream_sequencer #(
        .X_SIZE  (X_SIZE),
        .Y_SIZE  (Y_SIZE),
        .XW      (XW),
        .YW      (YW),
        .LINE_GAP(LINE_GAP)
    ) dut (
        .out_stream_aclk  (clk),
        .periph_resetn    (rst_n),
        .ctrl_run         (ctrl_run),
        .ctrl_single      (ctrl_single),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_data         (pix_data),
        .out_stream_tdata (tdata),
        .out_stream_tkeep (tkeep),
        .out_stream_tlast (tlast),
        .out_stream_tuser (tuser),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    int n_assert     = 0;
    int n_fail       = 0;
    int beat_idx     = 0;
    int valid_cycles = 0;
    int gap_cycles   = 0;
    bit rand_ready   = 1'b0;
    bit fc_checked   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: optionally re-randomise tready, sample at the falling edge,
    // check any valid beat against its expected stream position, then return
    // 1 time unit after the rising edge where the caller drives inputs.
    task automatic tick();
        int          k;
        logic [31:0] exp_data;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (tvalid) begin
            valid_cycles++;
            k        = beat_idx % FRAME_BEATS;
            exp_data = 32'(((k / X_SIZE) << 10) | (k % X_SIZE));
            chk($sformatf("tdata_beat%0d", beat_idx), tdata, exp_data);
            chk($sformatf("tuser_beat%0d", beat_idx), 32'(tuser), 32'(k == 0));
            chk($sformatf("tlast_beat%0d", beat_idx), 32'(tlast), 32'((k % X_SIZE) == X_SIZE - 1));
            if (tready) beat_idx++;
        end else if (busy && beat_idx > 0) begin
            gap_cycles++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ctrl_run    = 1'b0;
        ctrl_single = 1'b0;
        tready      = 1'b1;
        rand_ready  = 1'b0;
        tick();
        tick();
        rst_n        = 1'b1;
        beat_idx     = 0;
        valid_cycles = 0;
        gap_cycles   = 0;
    endtask

    initial begin
        rst_n       = 1'b0;
        ctrl_run    = 1'b0;
        ctrl_single = 1'b0;
        tready      = 1'b1;

        // ---- single frame ----
        do_reset();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tkeep", 32'(tkeep), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);

        ctrl_single = 1'b1;
        tick();
        ctrl_single = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_tvalid", 32'(tvalid), 32'd0);
        tick();
        chk("sof_tvalid", 32'(tvalid), 32'd1);
        chk("sof_tuser", 32'(tuser), 32'd1);
        for (int i = 0; i < 200 && beat_idx < FRAME_BEATS; i++) tick();
        chk("single_beats", 32'(beat_idx), 32'(FRAME_BEATS));
        chk("single_busy_after_last", 32'(busy), 32'd0);
        chk("single_frame_count", 32'(frame_count), 32'd1);
        chk("single_gap_cycles", 32'(gap_cycles), 32'(GAP_CYC * (Y_SIZE - 1)));
        valid_cycles = 0;
        repeat (100) tick();
        chk("single_idle_valid", 32'(valid_cycles), 32'd0);

        // ---- continuous run, dropped in the third frame ----
        do_reset();
        ctrl_run = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (beat_idx >= 30) ctrl_run = 1'b0;
            if (beat_idx >= 30 && !busy) break;
        end
        chk("run_beats", 32'(beat_idx), 32'(3 * FRAME_BEATS));
        chk("run_frame_count", 32'(frame_count), 32'd3);
        chk("run_gap_cycles", 32'(gap_cycles), 32'(GAP_CYC * (3 * Y_SIZE - 1)));
        chk("run_busy", 32'(busy), 32'd0);

        // ---- continuous run with random backpressure ----
        do_reset();
        ctrl_run   = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (beat_idx == 20 && !fc_checked) begin
                fc_checked = 1'b1;
                chk("stall_mid_frame_count", 32'(frame_count), 32'd1);
            end
            if (beat_idx >= 26) ctrl_run = 1'b0;
            if (beat_idx >= 26 && !busy) break;
        end
        rand_ready = 1'b0;
        tready     = 1'b1;
        chk("stall_mid_checked", 32'(fc_checked), 32'd1);
        chk("stall_beats", 32'(beat_idx), 32'(3 * FRAME_BEATS));
        chk("stall_frame_count", 32'(frame_count), 32'd3);

        // ---- asynchronous reset mid-line ----
        do_reset();
        ctrl_run = 1'b1;
        for (int i = 0; i < 100 && beat_idx < 6; i++) tick();
        chk("mrst_reached_beat6", 32'(beat_idx), 32'd6);
        chk("mrst_pre_tvalid", 32'(tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_tvalid", 32'(tvalid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_tdata", tdata, 32'd0);
        chk("mrst_pix_x", 32'(pix_x), 32'd0);
        chk("mrst_pix_y", 32'(pix_y), 32'd0);
        tick();
        rst_n        = 1'b1;
        beat_idx     = 0;
        gap_cycles   = 0;
        valid_cycles = 0;
        for (int i = 0; i < 20 && beat_idx < 1; i++) tick();
        chk("mrst_first_beat_seen", 32'(beat_idx), 32'd1);
        ctrl_run = 1'b0;

        // ---- ctrl_single while busy is ignored ----
        do_reset();
        ctrl_single = 1'b1;
        tick();
        ctrl_single = 1'b0;
        for (int i = 0; i < 100 && beat_idx < 5; i++) tick();
        ctrl_single = 1'b1;
        tick();
        ctrl_single = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick();
        repeat (20) tick();
        chk("busy_single_beats", 32'(beat_idx), 32'(FRAME_BEATS));
        chk("busy_single_frame_count", 32'(frame_count), 32'd1);
        chk("busy_single_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
